// File: rtl/inst_fetch_unit.sv
// Instruction fetch/sequencer: loadable program memory, pc and
// issue FSM, advanced by a free-running tick or a debounced button.
module inst_fetch_unit #(
  parameter int         ADDR_W          = 4,
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter int         RUN_DIV         = 50000000,
  parameter logic [5:0] HALT_OP         = 6'b111111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              step_btn,
  input  logic              restart,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int RUN_W = $clog2(RUN_DIV);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALT
  } state_e;

  state_e            state_q;
  logic [31:0]       mem_q [DEPTH];
  logic [31:0]       rdata_q;
  logic [31:0]       inst_q;
  logic              valid_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              halted_q;

  logic [RUN_W-1:0]  run_cnt_q;
  logic [1:0]        sync_q;
  logic              db_level_q;
  logic [DB_W-1:0]   db_cnt_q;

  logic              run_tick;
  logic              step_rise;
  logic              advance;
  logic              wr_ok;

  assign run_tick  = run && (run_cnt_q == RUN_LAST);
  assign step_rise = sync_q[1] && !db_level_q
                   && (db_cnt_q == DB_LAST);
  assign advance   = run ? run_tick : step_rise;
  assign pc_d      = pc_q + 1'b1;
  assign wr_ok     = restart || (state_q == IDLE)
                   || (state_q == HALT);

  // Run-mode divider: counts only while run is high, wraps on tick.
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      run_cnt_q <= '0;
    end else if (run_cnt_q == RUN_LAST) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_q + 1'b1;
    end
  end

  // Button synchroniser and stability counter for the debounced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      sync_q <= {sync_q[0], step_btn};
      if (sync_q[1] == db_level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_level_q <= sync_q[1];
        db_cnt_q   <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  // Program memory writes, blocked while an issue is in flight.
  always_ff @(posedge clk) begin
    if (prog_we && wr_ok) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      inst_q   <= '0;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else if (restart) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (advance) state_q <= FETCH;
        end
        FETCH: begin
          rdata_q <= mem_q[pc_q];
          state_q <= ISSUE;
        end
        ISSUE: begin
          if (rdata_q[31:26] == HALT_OP) begin
            halted_q <= 1'b1;
            state_q  <= HALT;
          end else begin
            inst_q  <= rdata_q;
            valid_q <= 1'b1;
            pc_q    <= pc_d;
            state_q <= IDLE;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign pc         = pc_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: load, run, step/debounce,
// wrap, restart/halt, abort and blocked writes.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        step_btn = 1'b0;
  logic        restart = 1'b0;
  logic        prog_we = 1'b0;
  logic [1:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [1:0]  pc;
  logic        halted;

  int total = 0;
  int bad   = 0;

  inst_fetch_unit #(
    .ADDR_W         (2),
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV        (8),
    .HALT_OP        (6'b111111)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step_btn  (step_btn),
    .restart   (restart),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .inst      (inst),
    .inst_valid(inst_valid),
    .pc        (pc),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Tick until inst_valid is seen or the budget runs out.
  task automatic wait_iv(input int maxc, output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      tick();
      n++;
      if (inst_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic write_mem(input logic [1:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  int n;
  bit ok;
  int pulses;
  int first;
  logic [31:0] exp_inst [4];
  logic [1:0]  exp_pc [5];
  logic [31:0] wrap_w [4];

  initial begin
    // Reset and load
    tick();
    tick();
    rst = 1'b0;
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", {30'd0, pc}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    write_mem(2'd0, 32'h90A20800);
    write_mem(2'd1, 32'hB0A30800);
    write_mem(2'd2, 32'hFC000000);
    write_mem(2'd3, 32'h12345678);
    chk("load_inst", inst, 32'h0);
    chk("load_pc", {30'd0, pc}, 32'd0);
    chk("load_valid", {31'd0, inst_valid}, 32'd0);
    chk("load_halted", {31'd0, halted}, 32'd0);

    // Run mode
    run = 1'b1;
    wait_iv(30, n, ok);
    chk("run1_seen", {31'd0, ok}, 32'd1);
    chk("run1_inst", inst, 32'h90A20800);
    chk("run1_pc", {30'd0, pc}, 32'd1);
    wait_iv(20, n, ok);
    chk("run2_seen", {31'd0, ok}, 32'd1);
    chk("run2_gap", n, 32'd8);
    chk("run2_inst", inst, 32'hB0A30800);
    chk("run2_pc", {30'd0, pc}, 32'd2);
    n = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (inst_valid) pulses++;
      if (halted) break;
    end
    chk("halt_seen", {31'd0, halted}, 32'd1);
    chk("halt_gap", n, 32'd8);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (inst_valid) pulses++;
    end
    chk("halt_no_pulse", pulses, 32'd0);
    chk("halt_pc", {30'd0, pc}, 32'd2);
    chk("halt_inst", inst, 32'hB0A30800);
    chk("halt_hold", {31'd0, halted}, 32'd1);
    run = 1'b0;
    tick();

    // Restart together with a program write
    restart   = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 2'd2;
    prog_data = 32'h0;
    tick();
    restart = 1'b0;
    prog_we = 1'b0;
    chk("rs_halted", {31'd0, halted}, 32'd0);
    chk("rs_pc", {30'd0, pc}, 32'd0);
    chk("rs_inst_held", inst, 32'hB0A30800);
    chk("rs_valid", {31'd0, inst_valid}, 32'd0);
    exp_inst[0] = 32'h90A20800;
    exp_inst[1] = 32'hB0A30800;
    exp_inst[2] = 32'h00000000;
    exp_inst[3] = 32'h12345678;
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_iv(30, n, ok);
      chk($sformatf("rs_seen%0d", k), {31'd0, ok}, 32'd1);
      chk($sformatf("rs_inst%0d", k), inst, exp_inst[k]);
      chk($sformatf("rs_pc%0d", k), {30'd0, pc},
          32'((k + 1) % 4));
    end
    run = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // Step mode: glitch is filtered
    step_btn = 1'b1;
    tick();
    tick();
    tick();
    step_btn = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (inst_valid) pulses++;
    end
    chk("glitch_none", pulses, 32'd0);
    chk("glitch_pc", {30'd0, pc}, 32'd0);

    // Step mode: long press issues exactly once
    step_btn = 1'b1;
    pulses = 0;
    first  = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (inst_valid) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("press_once", pulses, 32'd1);
    chk("press_lat", first, 32'd8);
    chk("press_inst", inst, 32'h90A20800);
    chk("press_pc", {30'd0, pc}, 32'd1);
    step_btn = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (inst_valid) pulses++;
    end
    chk("release_none", pulses, 32'd0);

    // Wrap: four nonzero words, five steps
    wrap_w[0] = 32'h11111111;
    wrap_w[1] = 32'h22222222;
    wrap_w[2] = 32'h33333333;
    wrap_w[3] = 32'h44444444;
    for (int k = 0; k < 4; k++) write_mem(2'(k), wrap_w[k]);
    pulse_restart();
    chk("wrap_start_pc", {30'd0, pc}, 32'd0);
    exp_pc[0] = 2'd1;
    exp_pc[1] = 2'd2;
    exp_pc[2] = 2'd3;
    exp_pc[3] = 2'd0;
    exp_pc[4] = 2'd1;
    for (int k = 0; k < 5; k++) begin
      step_btn = 1'b1;
      wait_iv(15, n, ok);
      chk($sformatf("wrap_seen%0d", k), {31'd0, ok}, 32'd1);
      chk($sformatf("wrap_pc%0d", k), {30'd0, pc},
          {30'd0, exp_pc[k]});
      chk($sformatf("wrap_inst%0d", k), inst, wrap_w[k % 4]);
      step_btn = 1'b0;
      for (int i = 0; i < 10; i++) tick();
    end

    // Reset during ISSUE aborts the issue
    step_btn = 1'b1;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (inst_valid) pulses++;
    end
    rst      = 1'b1;
    step_btn = 1'b0;
    tick();
    rst = 1'b0;
    if (inst_valid) pulses++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (inst_valid) pulses++;
    end
    chk("abort_none", pulses, 32'd0);
    chk("abort_pc", {30'd0, pc}, 32'd0);
    chk("abort_inst", inst, 32'h0);

    // Write during FETCH is ignored
    step_btn = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    prog_we   = 1'b1;
    prog_addr = 2'd0;
    prog_data = 32'hDEADBEEF;
    tick();
    prog_we = 1'b0;
    tick();
    chk("fw_valid", {31'd0, inst_valid}, 32'd1);
    chk("fw_inst", inst, 32'h11111111);
    step_btn = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    pulse_restart();
    step_btn = 1'b1;
    wait_iv(15, n, ok);
    chk("rb_seen", {31'd0, ok}, 32'd1);
    chk("rb_inst", inst, 32'h11111111);
    chk("rb_pc", {30'd0, pc}, 32'd1);
    step_btn = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch/sequencer stage; sits directly upstream of the register-file/ALU datapath in the single-cycle lab core.
- Holds a small loadable program memory and a program counter, and issues one 32-bit instruction at a time.
- Issue is either free-running (fixed tick) or single-stepped from a debounced push button.
- `inst` drives the decode fields: A1=[25:21], A2=[20:16], A3=[15:11], ALUControl=[29:27]. `inst_valid` is the one-cycle register-file write enable.

Parameters:
- ADDR_W, 4, program memory address width; DEPTH = 2**ADDR_W words of 32 bits.
- DEBOUNCE_CYCLES, 500000, cycles the synchronised step_btn must hold a new level before it is accepted (min 2).
- RUN_DIV, 50000000, run-mode issue period in cycles (min 4).
- HALT_OP, 6'b111111, opcode in inst[31:26] that stops sequencing.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- run  in  1  1 = free-run mode, 0 = single-step mode
- step_btn  in  1  raw asynchronous push button
- restart  in  1  synchronous pulse: pc to 0, clears halt
- prog_we  in  1  program memory write enable
- prog_addr  in  ADDR_W  program memory write address
- prog_data  in  32  program memory write data
- inst  out  32  last issued instruction, held stable between issues
- inst_valid  out  1  one-cycle pulse per issued instruction
- pc  out  ADDR_W  address of next instruction to fetch
- halted  out  1  high while stopped on HALT_OP

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - inst=0, inst_valid=0, pc=0, halted=0, state=IDLE.
  - Debounce counter, synchroniser, debounced level and run tick counter all cleared.
  - Memory contents are not affected by rst.
- States:
  - IDLE: wait for an advance. In run mode, advance = run tick; in step mode, advance = rising edge of the debounced button.
  - FETCH: synchronous memory read at pc.
  - ISSUE: evaluate the read data.
  - HALT: stopped on HALT_OP.
- Transitions:
  - IDLE->FETCH on advance.
  - FETCH->ISSUE unconditionally.
  - ISSUE->IDLE for normal instructions.
  - ISSUE->HALT when data[31:26]==HALT_OP.
  - HALT->IDLE only on restart.
- Issue timing (edge E0 accepts the advance, state goes to FETCH):
  - E1: read data registered, state goes to ISSUE.
  - E2: inst<=data, inst_valid<=1, pc<=pc+1, state goes to IDLE.
  - inst_valid is high for exactly the one cycle after E2.
- HALT at E2: inst and pc unchanged, inst_valid stays 0, halted<=1.
- pc arithmetic: unsigned modulo DEPTH; pc=DEPTH-1 wraps to 0 after issue. The all-zero word issues as a normal instruction (NOP).
- Run tick:
  - Counter runs only while run=1, counting 0..RUN_DIV-1; the tick pulses on wrap.
  - Counter clears when run=0.
  - A tick arriving outside IDLE is dropped.
- Step path:
  - 2-FF synchroniser, then a stability counter.
  - The debounced level changes after DEBOUNCE_CYCLES consecutive equal samples differing from it.
  - Only the 0->1 edge generates a step. Steps are ignored when run=1 or when not in IDLE.
- Mode change mid-operation: an issue already in FETCH/ISSUE completes; the new mode applies from the next IDLE decision.
- restart:
  - Honoured in any state; priority below rst, above everything else.
  - Next edge: pc=0, halted=0, state=IDLE, inst_valid=0, inst held.
- Program writes:
  - Honoured only in IDLE or HALT; ignored in FETCH/ISSUE.
  - Writes take effect at the clock edge.
  - prog_we together with restart: both are performed.
- rst mid-issue: the issue is aborted; inst_valid never pulses.

Test Plan:
- Reset/load:
  - Stimulus: rst, then write mem[0]=0x90A20800, mem[1]=0xB0A30800, mem[2]=0xFC000000 in IDLE.
  - Required: inst=0, pc=0, inst_valid=0, halted=0 throughout.
- Run mode (RUN_DIV=8):
  - Stimulus: run=1.
  - Required: inst_valid pulses 8 cycles apart with inst=0x90A20800 then 0xB0A30800, pc 1 then 2.
  - Required: on the third fetch, halted=1, pc stays 2, no third pulse, inst holds 0xB0A30800.
- Step/debounce (DEBOUNCE_CYCLES=4, run=0):
  - Stimulus: 3-cycle glitch on step_btn.
  - Required: no issue.
  - Stimulus: 10-cycle press.
  - Required: exactly one inst_valid, 2 cycles after the debounced rise.
  - Stimulus: holding the button.
  - Required: no further issues.
- Wrap (ADDR_W=2):
  - Stimulus: all four words nonzero, non-halt; step 5 times.
  - Required: pc sequence 1,2,3,0,1; fifth inst equals mem[0].
- Restart/halt:
  - Stimulus: from halted, pulse restart with prog_we writing mem[2]=0.
  - Required: next edge halted=0, pc=0.
  - Required: subsequent run issues 0x90A20800, 0xB0A30800, 0x00000000, then mem[3].
- Abort and ignored write:
  - Stimulus: rst asserted during ISSUE.
  - Required: no inst_valid pulse, pc=0.
  - Stimulus: prog_we during FETCH.
  - Required: memory unchanged on readback.
